pe_mac: RTL and testbench

//  Parametrised systolic-array processing element: multiply-accumulate over a framed operand stream.

---
 rtl/pe_pkg.sv | 25 ++
 rtl/pe_mul_pipe.sv | 83 ++++++++
 rtl/pe_mac.sv | 278 +++++++++++++++++++++++++++
 tb/tb_pe_mac.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// ---------------------------------------------------------------------------
// pe_pkg
//   Shared definitions for the pe_mac processing element.
//   - pe_state_e    : control FSM encoding (IDLE / ACC / FLUSH)
//   - MUL_LAT_MIN/MAX: legal multiplier pipeline depth range
//   - ext_bit()     : fill bit used when widening an operand or a product
// ---------------------------------------------------------------------------
package pe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FLUSH = 2'd2
    } pe_state_e;

    localparam int MUL_LAT_MIN = 1;
    localparam int MUL_LAT_MAX = 4;

    // Bit replicated into the upper part of a widened value: the sign bit for
    // two's-complement data, zero for unsigned data.
    function automatic logic ext_bit(input logic msb, input logic is_signed);
        return msb & is_signed;
    endfunction

endpackage

// File: rtl/pe_mul_pipe.sv
// ---------------------------------------------------------------------------
// pe_mul_pipe
//   MUL_LAT-stage multiplier. The product of i_a * i_b (2*DATA_W bits,
//   signed or unsigned per SIGNED) appears on o_prod exactly MUL_LAT cycles
//   after the pair is presented, together with its valid/first/last tags.
//   Only the valid bits are reset; data and tags are don't-care when invalid.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_vld               pair valid (issue strobe)
//   i_first, i_last     dot-product framing tags travelling with the pair
//   i_a, i_b            operands, DATA_W bits
//   o_vld, o_first,
//   o_last              delayed tags
//   o_prod              product, 2*DATA_W bits
// ---------------------------------------------------------------------------
module pe_mul_pipe
    import pe_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MUL_LAT = 2,
    parameter int SIGNED  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_vld,
    input  logic                  i_first,
    input  logic                  i_last,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic                  o_vld,
    output logic                  o_first,
    output logic                  o_last,
    output logic [2*DATA_W-1:0]   o_prod
);

    // Out-of-range depths are clamped to the supported range.
    localparam int LAT = (MUL_LAT < MUL_LAT_MIN) ? MUL_LAT_MIN :
                         (MUL_LAT > MUL_LAT_MAX) ? MUL_LAT_MAX : MUL_LAT;

    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic [2*DATA_W-1:0] w_prod;

    logic [LAT-1:0]      r_vld;
    logic [LAT-1:0]      r_first;
    logic [LAT-1:0]      r_last;
    logic [2*DATA_W-1:0] r_prod [LAT];

    // The low 2*DATA_W bits of the product of the widened operands equal the
    // true signed (or unsigned) product, so one multiplier serves both modes.
    assign w_a_ext = {{DATA_W{ext_bit(i_a[DATA_W-1], SIGNED != 0)}}, i_a};
    assign w_b_ext = {{DATA_W{ext_bit(i_b[DATA_W-1], SIGNED != 0)}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= i_vld;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        r_first[0] <= i_first;
        r_last[0]  <= i_last;
        r_prod[0]  <= w_prod;
        for (int i = 1; i < LAT; i++) begin
            r_first[i] <= r_first[i-1];
            r_last[i]  <= r_last[i-1];
            r_prod[i]  <= r_prod[i-1];
        end
    end

    assign o_vld   = r_vld[LAT-1];
    assign o_first = r_first[LAT-1];
    assign o_last  = r_last[LAT-1];
    assign o_prod  = r_prod[LAT-1];

endmodule

// File: rtl/pe_mac.sv
// ---------------------------------------------------------------------------
// pe_mac
//   Systolic-array processing element. West/north operands are forwarded
//   east/south one cycle later; matched operand pairs are multiplied
//   (pe_mul_pipe) and accumulated into a dot product framed by first/last
//   tags. Finished results wait in a ready/valid holding register.
//
// Build option
//   PE_MAC_SAT_EN : saturating accumulate (clamp to ACC_W max/min) and an
//                   extra o_res_sat output flagging a clamped result.
//                   Undefined: modular wrap, no o_res_sat port.
//
// Ports
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_pe_en                    enables MAC issue (forwarding always runs)
//   i_in0_vld/i_in0_data       west operand
//   i_in1_vld/i_in1_data       north operand
//   i_in_first, i_in_last      framing tags of the issued pair
//   o_out0_vld/o_out0_data     east forward
//   o_out1_vld/o_out1_data     south forward
//   o_res_vld, i_res_rdy       result handshake
//   o_res_data, o_res_cnt      dot product and its MAC count
//   o_res_ovr                  sticky: unread result overwritten
//   o_drop_err                 sticky: issue attempted during FLUSH
//   o_pe_doing                 FSM in ACC or FLUSH
//   o_res_sat                  (PE_MAC_SAT_EN only) result was clamped
//
// FSM
//   state    | meaning
//   ST_IDLE  | no dot product open; next fire is treated as first
//   ST_ACC   | dot product open, issuing MACs
//   ST_FLUSH | last pair issued, waiting for it to leave the multiplier
// ---------------------------------------------------------------------------
module pe_mac
    import pe_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int MUL_LAT = 2,
    parameter int SIGNED  = 1,
    parameter int CNT_W   = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_pe_en,
    input  logic                i_in0_vld,
    input  logic [DATA_W-1:0]   i_in0_data,
    input  logic                i_in1_vld,
    input  logic [DATA_W-1:0]   i_in1_data,
    input  logic                i_in_first,
    input  logic                i_in_last,
    output logic                o_out0_vld,
    output logic [DATA_W-1:0]   o_out0_data,
    output logic                o_out1_vld,
    output logic [DATA_W-1:0]   o_out1_data,
    output logic                o_res_vld,
    input  logic                i_res_rdy,
    output logic [ACC_W-1:0]    o_res_data,
    output logic [CNT_W-1:0]    o_res_cnt,
    output logic                o_res_ovr,
    output logic                o_drop_err,
    output logic                o_pe_doing
`ifdef PE_MAC_SAT_EN
    ,
    output logic                o_res_sat
`endif
);

    pe_state_e r_state;
    pe_state_e w_state_nxt;

    logic                r_out0_vld;
    logic [DATA_W-1:0]   r_out0_data;
    logic                r_out1_vld;
    logic [DATA_W-1:0]   r_out1_data;

    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_res_vld;
    logic [ACC_W-1:0]    r_res_data;
    logic [CNT_W-1:0]    r_res_cnt;
    logic                r_res_ovr;
    logic                r_drop_err;

    logic                w_pair;
    logic                w_fire;
    logic                w_drop;
    logic                w_first_tag;

    logic                w_pipe_vld;
    logic                w_pipe_first;
    logic                w_pipe_last;
    logic [2*DATA_W-1:0] w_pipe_prod;
    logic [ACC_W-1:0]    w_prod_acc;

    logic [ACC_W-1:0]    w_acc_add;
    logic [ACC_W-1:0]    w_acc_new;
    logic [CNT_W-1:0]    w_cnt_new;

    assign w_pair      = i_in0_vld & i_in1_vld & i_pe_en;
    assign w_fire      = w_pair & (r_state != ST_FLUSH);
    assign w_drop      = w_pair & (r_state == ST_FLUSH);
    // Opening a dot product from IDLE always starts a fresh sum.
    assign w_first_tag = i_in_first | (r_state == ST_IDLE);

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out0_vld  <= 1'b0;
            r_out0_data <= '0;
            r_out1_vld  <= 1'b0;
            r_out1_data <= '0;
        end else begin
            r_out0_vld <= i_in0_vld;
            r_out1_vld <= i_in1_vld;
            if (i_in0_vld) r_out0_data <= i_in0_data;
            if (i_in1_vld) r_out1_data <= i_in1_data;
        end
    end

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    pe_mul_pipe #(
        .DATA_W  (DATA_W),
        .MUL_LAT (MUL_LAT),
        .SIGNED  (SIGNED)
    ) u_mul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_vld   (w_fire),
        .i_first (w_first_tag),
        .i_last  (i_in_last),
        .i_a     (i_in0_data),
        .i_b     (i_in1_data),
        .o_vld   (w_pipe_vld),
        .o_first (w_pipe_first),
        .o_last  (w_pipe_last),
        .o_prod  (w_pipe_prod)
    );

    generate
        if (ACC_W > 2*DATA_W) begin : g_prod_ext
            logic w_ext;
            assign w_ext      = ext_bit(w_pipe_prod[2*DATA_W-1], SIGNED != 0);
            assign w_prod_acc = {{(ACC_W-2*DATA_W){w_ext}}, w_pipe_prod};
        end else begin : g_prod_same
            assign w_prod_acc = w_pipe_prod;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fire) w_state_nxt = i_in_last ? ST_FLUSH : ST_ACC;
            end
            ST_ACC: begin
                if (w_fire && i_in_last) w_state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (w_pipe_vld && w_pipe_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulate
    // ------------------------------------------------------------------
`ifdef PE_MAC_SAT_EN
    logic [ACC_W:0]   w_sum_ext;
    logic             w_ovf;
    logic [ACC_W-1:0] w_clamp;
    logic             r_sat;
    logic             w_sat_new;
    logic             r_res_sat;

    always_comb begin
        w_sum_ext = {1'b0, r_acc} + {1'b0, w_prod_acc};
        w_ovf     = 1'b0;
        w_clamp   = '1;
        if (SIGNED != 0) begin
            // Overflow only when both addends share a sign the sum lacks.
            w_ovf   = (r_acc[ACC_W-1] == w_prod_acc[ACC_W-1]) &&
                      (w_sum_ext[ACC_W-1] != r_acc[ACC_W-1]);
            w_clamp = r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            w_ovf   = w_sum_ext[ACC_W];
            w_clamp = '1;
        end
        w_acc_add = w_ovf ? w_clamp : w_sum_ext[ACC_W-1:0];
        // A lone product always fits in ACC_W, so a first never clamps.
        w_sat_new = w_pipe_first ? 1'b0 : (r_sat | w_ovf);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sat     <= 1'b0;
            r_res_sat <= 1'b0;
        end else if (w_pipe_vld) begin
            r_sat <= w_sat_new;
            if (w_pipe_last) r_res_sat <= w_sat_new;
        end
    end

    assign o_res_sat = r_res_sat;
`else
    always_comb begin
        w_acc_add = r_acc + w_prod_acc;
    end
`endif

    always_comb begin
        w_acc_new = w_acc_add;
        w_cnt_new = r_cnt + CNT_W'(1);
        if (w_pipe_first) begin
            w_acc_new = w_prod_acc;
            w_cnt_new = CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_pipe_vld) begin
            r_acc <= w_acc_new;
            r_cnt <= w_cnt_new;
        end
    end

    // ------------------------------------------------------------------
    // Result holding register and sticky flags
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_res_vld  <= 1'b0;
            r_res_data <= '0;
            r_res_cnt  <= '0;
            r_res_ovr  <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_pipe_vld && w_pipe_last) begin
                r_res_vld  <= 1'b1;
                r_res_data <= w_acc_new;
                r_res_cnt  <= w_cnt_new;
                if (r_res_vld && !i_res_rdy) r_res_ovr <= 1'b1;
            end else if (r_res_vld && i_res_rdy) begin
                r_res_vld <= 1'b0;
            end
            if (w_drop) r_drop_err <= 1'b1;
        end
    end

    assign o_out0_vld  = r_out0_vld;
    assign o_out0_data = r_out0_data;
    assign o_out1_vld  = r_out1_vld;
    assign o_out1_data = r_out1_data;
    assign o_res_vld   = r_res_vld;
    assign o_res_data  = r_res_data;
    assign o_res_cnt   = r_res_cnt;
    assign o_res_ovr   = r_res_ovr;
    assign o_drop_err  = r_drop_err;
    assign o_pe_doing  = (r_state == ST_ACC) || (r_state == ST_FLUSH);

endmodule

// File: tb/tb_pe_mac.sv
// ---------------------------------------------------------------------------
// tb_pe_mac
//   Directed bench for pe_mac. Instance u_dut_s: DATA_W=8, ACC_W=32,
//   MUL_LAT=2, signed. Instance u_dut_u: unsigned, ACC_W=16, sharing the
//   same stimulus. PE_MAC_SAT_EN selects the saturating expectations.
// ---------------------------------------------------------------------------
module tb_pe_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        pe_en;
    logic        in0_vld, in1_vld;
    logic [7:0]  in0_data, in1_data;
    logic        in_first, in_last;
    logic        res_rdy;

    logic        a_out0_vld, a_out1_vld, a_res_vld, a_res_ovr, a_drop_err, a_pe_doing;
    logic [7:0]  a_out0_data, a_out1_data;
    logic [31:0] a_res_data;
    logic [15:0] a_res_cnt;

    logic        b_out0_vld, b_out1_vld, b_res_vld, b_res_ovr, b_drop_err, b_pe_doing;
    logic [7:0]  b_out0_data, b_out1_data;
    logic [15:0] b_res_data;
    logic [15:0] b_res_cnt;

`ifdef PE_MAC_SAT_EN
    logic        a_res_sat, b_res_sat;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    pe_mac #(.DATA_W(8), .ACC_W(32), .MUL_LAT(2), .SIGNED(1), .CNT_W(16)) u_dut_s (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pe_en     (pe_en),
        .i_in0_vld   (in0_vld),
        .i_in0_data  (in0_data),
        .i_in1_vld   (in1_vld),
        .i_in1_data  (in1_data),
        .i_in_first  (in_first),
        .i_in_last   (in_last),
        .o_out0_vld  (a_out0_vld),
        .o_out0_data (a_out0_data),
        .o_out1_vld  (a_out1_vld),
        .o_out1_data (a_out1_data),
        .o_res_vld   (a_res_vld),
        .i_res_rdy   (res_rdy),
        .o_res_data  (a_res_data),
        .o_res_cnt   (a_res_cnt),
        .o_res_ovr   (a_res_ovr),
        .o_drop_err  (a_drop_err),
        .o_pe_doing  (a_pe_doing)
`ifdef PE_MAC_SAT_EN
        ,
        .o_res_sat   (a_res_sat)
`endif
    );

    pe_mac #(.DATA_W(8), .ACC_W(16), .MUL_LAT(2), .SIGNED(0), .CNT_W(16)) u_dut_u (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_pe_en     (pe_en),
        .i_in0_vld   (in0_vld),
        .i_in0_data  (in0_data),
        .i_in1_vld   (in1_vld),
        .i_in1_data  (in1_data),
        .i_in_first  (in_first),
        .i_in_last   (in_last),
        .o_out0_vld  (b_out0_vld),
        .o_out0_data (b_out0_data),
        .o_out1_vld  (b_out1_vld),
        .o_out1_data (b_out1_data),
        .o_res_vld   (b_res_vld),
        .i_res_rdy   (res_rdy),
        .o_res_data  (b_res_data),
        .o_res_cnt   (b_res_cnt),
        .o_res_ovr   (b_res_ovr),
        .o_drop_err  (b_drop_err),
        .o_pe_doing  (b_pe_doing)
`ifdef PE_MAC_SAT_EN
        ,
        .o_res_sat   (b_res_sat)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic f, input logic l);
        in0_vld  = 1'b1;
        in1_vld  = 1'b1;
        in0_data = a;
        in1_data = b;
        in_first = f;
        in_last  = l;
        tick();
    endtask

    task automatic idle();
        in0_vld  = 1'b0;
        in1_vld  = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        res_rdy = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
    endtask

    task automatic accept();
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
    endtask

    // Bounded wait for a result on the signed (sel=0) or unsigned (sel=1) PE.
    task automatic wait_res(input string tag, input bit sel);
        for (int i = 0; i < 10; i++) begin
            if ((sel ? b_res_vld : a_res_vld) == 1'b1) break;
            tick();
        end
        chk(tag, sel ? b_res_vld : a_res_vld, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        pe_en    = 1'b1;
        in0_data = 8'h00;
        in1_data = 8'h00;
        do_reset();

        // reset state
        chk("rst_res_vld",  a_res_vld, 0);
        chk("rst_res_data", a_res_data, 0);
        chk("rst_res_cnt",  a_res_cnt, 0);
        chk("rst_res_ovr",  a_res_ovr, 0);
        chk("rst_drop_err", a_drop_err, 0);
        chk("rst_pe_doing", a_pe_doing, 0);
        chk("rst_out0_vld", a_out0_vld, 0);
        chk("rst_out1_vld", a_out1_vld, 0);

        // 1) (3,4)+(-2,5)+(7,-1) = -5, latency MUL_LAT+1 from last fire
        send(8'd3,  8'd4,  1'b1, 1'b0);
        chk("t1_doing_acc", a_pe_doing, 1);
        send(8'hFE, 8'd5,  1'b0, 1'b0);
        send(8'd7,  8'hFF, 1'b0, 1'b1);
        idle();
        chk("t1_lat0", a_res_vld, 0);
        chk("t1_doing_flush", a_pe_doing, 1);
        tick();
        chk("t1_lat1", a_res_vld, 0);
        tick();
        chk("t1_lat2", a_res_vld, 1);
        chk("t1_data", a_res_data, 64'hFFFF_FFFB);
        chk("t1_cnt",  a_res_cnt, 3);
        chk("t1_doing_idle", a_pe_doing, 0);
        // unsigned view: 3*4 + 254*5 + 7*255 = 3067
        chk("t1_u_data", b_res_data, 16'h0BFB);
        chk("t1_u_cnt",  b_res_cnt, 3);
        accept();
        chk("t1_drained", a_res_vld, 0);

        // 2) forwarding with pe_en=0, no MAC
        pe_en    = 1'b0;
        in0_vld  = 1'b1;
        in1_vld  = 1'b1;
        in0_data = 8'h5A;
        in1_data = 8'h5A;
        tick();
        chk("t2_out0_vld",  a_out0_vld, 1);
        chk("t2_out0_data", a_out0_data, 8'h5A);
        chk("t2_out1_vld",  a_out1_vld, 1);
        chk("t2_out1_data", a_out1_data, 8'h5A);
        chk("t2_doing",     a_pe_doing, 0);
        idle();
        in0_data = 8'h33;
        in1_data = 8'h44;
        tick();
        chk("t2_out0_vld_off", a_out0_vld, 0);
        chk("t2_out0_hold",    a_out0_data, 8'h5A);
        chk("t2_out1_hold",    a_out1_data, 8'h5A);
        tick();
        tick();
        tick();
        chk("t2_no_res", a_res_vld, 0);
        pe_en = 1'b1;

        // 3) overrun with res_rdy held low
        send(8'd2, 8'd3, 1'b1, 1'b1);
        idle();
        wait_res("t3_res_a", 1'b0);
        chk("t3_data_a", a_res_data, 6);
        send(8'd4, 8'd5, 1'b1, 1'b1);
        idle();
        tick();
        tick();
        chk("t3_vld_b",  a_res_vld, 1);
        chk("t3_data_b", a_res_data, 20);
        chk("t3_ovr",    a_res_ovr, 1);
        do_reset();
        chk("t3_ovr_rst", a_res_ovr, 0);
        // accept coincides with the new result: no overrun
        send(8'd2, 8'd3, 1'b1, 1'b1);
        idle();
        wait_res("t3_res_c", 1'b0);
        send(8'd4, 8'd5, 1'b1, 1'b1);
        idle();
        tick();
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        chk("t3_vld_d",  a_res_vld, 1);
        chk("t3_data_d", a_res_data, 20);
        chk("t3_no_ovr", a_res_ovr, 0);
        accept();
        chk("t3_drained", a_res_vld, 0);

        // 4) fire in FLUSH is dropped
        send(8'd1, 8'd1, 1'b1, 1'b0);
        send(8'd2, 8'd2, 1'b0, 1'b1);
        send(8'd9, 8'd9, 1'b0, 1'b0);
        idle();
        chk("t4_drop_err", a_drop_err, 1);
        wait_res("t4_res", 1'b0);
        chk("t4_data", a_res_data, 5);
        chk("t4_cnt",  a_res_cnt, 2);
        accept();
        // restart with first inside ACC after 2 MACs
        send(8'd1, 8'd2, 1'b1, 1'b0);
        send(8'd3, 8'd4, 1'b0, 1'b0);
        send(8'd5, 8'd6, 1'b1, 1'b0);
        send(8'd1, 8'd1, 1'b0, 1'b1);
        idle();
        wait_res("t4_restart_res", 1'b0);
        chk("t4_restart_data", a_res_data, 31);
        chk("t4_restart_cnt",  a_res_cnt, 2);

        // 5) reset mid-ACC with an unread result and drop_err pending
        send(8'd1, 8'd2, 1'b1, 1'b0);
        send(8'd3, 8'd4, 1'b0, 1'b0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_res_vld",  a_res_vld, 0);
        chk("t5_res_data", a_res_data, 0);
        chk("t5_res_cnt",  a_res_cnt, 0);
        chk("t5_drop_err", a_drop_err, 0);
        chk("t5_doing",    a_pe_doing, 0);
        tick();
        tick();
        tick();
        tick();
        chk("t5_no_late_res", a_res_vld, 0);
        send(8'd6, 8'd7, 1'b1, 1'b1);
        idle();
        wait_res("t5_res", 1'b0);
        chk("t5_data", a_res_data, 42);
        chk("t5_cnt",  a_res_cnt, 1);

        // 6) unsigned 255*255 twice into 16 bits
        do_reset();
        send(8'hFF, 8'hFF, 1'b1, 1'b0);
        send(8'hFF, 8'hFF, 1'b0, 1'b1);
        idle();
        wait_res("t6_res", 1'b1);
`ifdef PE_MAC_SAT_EN
        chk("t6_u_data", b_res_data, 16'hFFFF);
        chk("t6_u_sat",  b_res_sat, 1);
        chk("t6_s_sat",  a_res_sat, 0);
`else
        chk("t6_u_data", b_res_data, 16'hFC02);
`endif
        chk("t6_u_cnt",  b_res_cnt, 2);
        chk("t6_s_data", a_res_data, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
